ram_fill_ctrl: RTL

RAM_FILL_CTRL -- requirements
Module: ram_fill_ctrl

---
 rtl/fill_pkg.sv | 14 +
 rtl/fill_pair_packer.sv | 94 +++++++++
 rtl/ram_fill_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fill_pkg.sv
// Shared types for the RAM fill controller: FSM state encoding and pair-index helper.
package fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } fill_state_e;

  // Bit of the word counter that marks the second word of a write pair.
  localparam int unsigned PAIR_BIT = 0;

endpackage

// File: rtl/fill_pair_packer.sv
// Pairs consecutive stream words into dual-port RAM writes; even words wait in a hold
// register, odd words issue (k-1, k) together, a trailing odd-length word goes out alone.
module fill_pair_packer
  import fill_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 6,
  parameter int LW    = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             xfer,
  input  logic             last,
  input  logic [LW-1:0]    k,
  input  logic [WIDTH-1:0] in_data,
  output logic             we_a,
  output logic             we_b,
  output logic [AW-1:0]    addr_a,
  output logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b
);

  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic             we_a_q, we_a_d, we_b_q, we_b_d;
  logic [AW-1:0]    addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [WIDTH-1:0] data_a_q, data_a_d, data_b_q, data_b_d;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    we_a_d     = 1'b0;
    we_b_d     = 1'b0;
    addr_a_d   = addr_a_q;
    addr_b_d   = addr_b_q;
    data_a_d   = data_a_q;
    data_b_d   = data_b_q;
    if (clear) begin
      hold_vld_d = 1'b0;
    end else if (xfer) begin
      if (k[PAIR_BIT]) begin
        if (hold_vld_q) begin
          we_a_d   = 1'b1;
          addr_a_d = AW'(k - LW'(1));
          data_a_d = hold_q;
          we_b_d   = 1'b1;
          addr_b_d = AW'(k);
          data_b_d = in_data;
        end
        hold_vld_d = 1'b0;
      end else if (last) begin
        we_a_d   = 1'b1;
        addr_a_d = AW'(k);
        data_a_d = in_data;
      end else begin
        hold_d     = in_data;
        hold_vld_d = 1'b1;
      end
    end
  end

  // Reset drops any half-built pair, so a pending write never reaches the RAM.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      we_a_q     <= 1'b0;
      we_b_q     <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      we_a_q     <= we_a_d;
      we_b_q     <= we_b_d;
      addr_a_q   <= addr_a_d;
      addr_b_q   <= addr_b_d;
      data_a_q   <= data_a_d;
      data_b_q   <= data_b_d;
    end
  end

  assign we_a   = we_a_q;
  assign we_b   = we_b_q;
  assign addr_a = addr_a_q;
  assign addr_b = addr_b_q;
  assign data_a = data_a_q;
  assign data_b = data_b_q;

endmodule

// File: rtl/ram_fill_ctrl.sv
// Frame fill controller: accepts a stream of frame_len words and writes them two per cycle
// into a dual-port RAM. Optional XOR checksum enabled by defining FILL_CHECKSUM_EN.
module ram_fill_ctrl
  import fill_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int HEIGHT = 48,
  parameter int AW     = $clog2(HEIGHT),
  parameter int LW     = $clog2(HEIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LW-1:0]    frame_len,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [AW-1:0]    addr_a,
  output logic [AW-1:0]    addr_b,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic             we_a,
  output logic             we_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] checksum
);

  localparam logic [LW-1:0] HEIGHT_L = LW'(HEIGHT);

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] len);
    return (len > HEIGHT_L) ? HEIGHT_L : len;
  endfunction

  fill_state_e   state_q, state_d;
  logic [LW-1:0] k_q, k_d;
  logic [LW-1:0] len_q, len_d;
  logic          clear;
  logic          xfer;
  logic          last;

  assign in_ready = (state_q == FILL) && (k_q < len_q);
  assign xfer     = in_valid && in_ready;
  assign last     = (k_q + LW'(1)) == len_q;
  assign busy     = (state_q == FILL) || (state_q == FLUSH);
  assign done     = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    len_d   = len_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = clamp_len(frame_len);
          k_d     = '0;
          clear   = 1'b1;
          state_d = (clamp_len(frame_len) == '0) ? DONE : FILL;
        end
      end
      FILL: begin
        if (xfer) begin
          k_d = k_q + LW'(1);
          if (last) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      len_q   <= len_d;
    end
  end

  fill_pair_packer #(
    .WIDTH (WIDTH),
    .AW    (AW),
    .LW    (LW)
  ) u_packer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .xfer    (xfer),
    .last    (last),
    .k       (k_q),
    .in_data (in_data),
    .we_a    (we_a),
    .we_b    (we_b),
    .addr_a  (addr_a),
    .addr_b  (addr_b),
    .data_a  (data_a),
    .data_b  (data_b)
  );

`ifdef FILL_CHECKSUM_EN
  logic [WIDTH-1:0] csum_q, csum_d;

  // The last word is folded in at the FLUSH edge, so the value is settled by DONE.
  always_comb begin
    csum_d = csum_q;
    if (clear)     csum_d = '0;
    else if (xfer) csum_d = csum_q ^ in_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) csum_q <= '0;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
